// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and the default reset PC.
package riscv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO with flush, generic entry type.
// The head entry is read straight from the storage registers (no bypass).
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A push at full is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch with prefetch FIFO and redirect flush.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = FIFO_DEPTH[CW:0];

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW:0]   in_use;
  logic          fifo_empty, fifo_full;
  logic          tag_empty, tag_full;
  fetch_entry_t  fifo_head, fifo_wdata;
  logic [31:0]   tag_pc;
  logic          grant, rsp, redir, misaligned;
  logic          rsp_keep, fifo_pop, fifo_flush;
  logic          unused_full;

  // Outstanding requests always have a reserved FIFO slot.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = (state_q == RUN) && (in_use < DEPTH_L);
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;
  // Responses are only counted against tagged in-flight requests.
  assign rsp         = imem_rvalid && (state_q != BOOT) && !tag_empty;
  assign redir       = redirect && (state_q != BOOT);
  assign rsp_keep    = rsp && !redir && (discard_q == '0) && (state_q == RUN);
  assign fifo_flush  = redir || (state_q == HALT);
  assign fifo_pop    = instr_valid && instr_ready;
  assign fifo_wdata  = '{pc: tag_pc, data: imem_rdata};
  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_head.data;
  assign instr_pc    = fifo_head.pc;
  assign unused_full = fifo_full ^ tag_full;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned  = |redirect_pc[1:0];
  assign fetch_fault = (state_q == HALT);
`else
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Next-state, PC and stale-response discard count.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redir && misaligned)  state_d = HALT;
      HALT:    if (redir && !misaligned) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redir) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      // Everything still in flight after this cycle is stale, including a grant now.
      discard_d = outstanding + CW'(grant) - CW'(rsp);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
    end
  end

  // State, PC and discard registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (fifo_flush),
    .push_i  (rsp_keep),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // In-flight PC tags; its occupancy is the outstanding request count.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [31:0])
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (1'b0),
    .push_i  (grant),
    .data_i  (pc_q),
    .pop_i   (rsp),
    .data_o  (tag_pc),
    .count_o (outstanding),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-randomized memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] expq[$];
  logic [31:0] next_exp;
  pend_t       pend[$];
  int unsigned cyc = 0, ngrant = 0, nhand = 0;
  int unsigned gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit          halted = 1'b0, exp_fault = 1'b0, prev_stall = 1'b0;
  logic [31:0] exp_gaddr, prev_addr;

  // Instruction memory contents as a fixed function of the word address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: memory response, grant, ready, optional redirect.
  task automatic step(input bit do_redir, input logic [31:0] tgt);
    pend_t p;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = memw(p.addr);
    end
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    redirect    = do_redir;
    redirect_pc = tgt;
    if (do_redir) begin
      expq.delete();
      next_exp = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      halted = (tgt[1:0] != 2'b00);
`endif
    end
    if (!halted) begin
      while (expq.size() < 8) begin
        expq.push_back(next_exp);
        next_exp = next_exp + 32'd4;
      end
    end
    #1;
    check("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
    if (prev_stall) begin
      check("stall_req_held", 32'(imem_req), 32'd1);
      check("stall_addr_held", imem_addr, prev_addr);
    end
    if (imem_req && imem_gnt) begin
      check("grant_addr", imem_addr, exp_gaddr);
      exp_gaddr = exp_gaddr + 32'd4;
      ngrant++;
      p.addr = imem_addr;
      p.due  = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(p);
    end
    if (do_redir) begin
      exp_gaddr = tgt & 32'hFFFF_FFFC;
      exp_fault = halted;
    end
    prev_stall = imem_req && !imem_gnt && !do_redir;
    prev_addr  = imem_addr;
  endtask

  // Asynchronous reset with junk responses on the bus during reset and BOOT.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    pend.delete();
    expq.delete();
    halted     = 1'b0;
    exp_fault  = 1'b0;
    prev_stall = 1'b0;
    exp_gaddr  = RPC;
    next_exp   = RPC;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RPC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("boot_no_req", 32'(imem_req), 32'd0);
  endtask

  // Scoreboard monitor: every decode handshake pops one expected entry.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (reset && instr_valid && instr_ready && !redirect) begin
        nhand++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, expected no delivery", instr_pc);
        end else begin
          e = expq.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr_data", instr_data, memw(e));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int unsigned h0, g0, n;
    logic [31:0] tgt;

    do_reset();

    // Sequential fetch from reset and sustained throughput.
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    step(1'b0, '0);
    check("first_req", 32'(imem_req), 32'd1);
    repeat (9) step(1'b0, '0);
    h0 = nhand;
    repeat (20) step(1'b0, '0);
    check("throughput", nhand - h0, 32'd20);

    // Back-pressure: four grants, then request drops with head at RESET_PC.
    do_reset();
    rdy_pct = 0;
    g0 = ngrant;
    repeat (12) step(1'b0, '0);
    check("bp_grants", ngrant - g0, 32'd4);
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", instr_pc, RPC);
    rdy_pct = 100;
    h0 = nhand;
    repeat (8) step(1'b0, '0);
    check("bp_drain", 32'(nhand - h0 >= 4), 32'd1);

    // Redirect with two responses in flight, coinciding with a grant.
    do_reset();
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(pend.size() >= 2 && imem_req) && n < 50) begin
      step(1'b0, '0);
      n++;
    end
    check("redir_setup", 32'(n < 50), 32'd1);
    step(1'b1, 32'h0000_0100);
    h0 = nhand;
    repeat (12) step(1'b0, '0);
    check("redir_progress", 32'(nhand - h0 >= 4), 32'd1);

    // Wrap-around at the top of the address space.
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC);
    h0 = nhand;
    repeat (10) step(1'b0, '0);
    check("wrap_progress", 32'(nhand - h0 >= 4), 32'd1);

    // Misaligned redirect target.
    step(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    g0 = ngrant;
    repeat (10) step(1'b0, '0);
    check("halt_no_grant", ngrant - g0, 32'd0);
    check("halt_req", 32'(imem_req), 32'd0);
    step(1'b1, 32'h0000_0200);
`endif
    h0 = nhand;
    repeat (12) step(1'b0, '0);
    check("misalign_progress", 32'(nhand - h0 >= 4), 32'd1);

    // Randomized traffic with redirects and one mid-run reset.
    gnt_pct = 70; rdy_pct = 75; lat_min = 1; lat_max = 3;
    h0 = nhand;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        tgt = $urandom;
        case ($urandom_range(3))
          0:       tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
          1:       tgt[1:0] = 2'b00;
          default: tgt = tgt & 32'h0000_0FFC;
        endcase
        step(1'b1, tgt);
      end else begin
        step(1'b0, '0);
      end
      if (i == 1500) begin
        do_reset();
      end
    end
    check("rand_progress", 32'(nhand - h0 > 500), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core, sitting directly upstream of the decode/execute CPU logic and supplying its `idata`/`iaddr` pair. It keeps a program counter and issues word requests to instruction memory over a request/grant and response handshake. Returned words are held in a small prefetch FIFO, and a valid/ready handshake delivers them to decode. A redirect port from branch/jump resolution flushes queued and in-flight fetches and restarts at a new PC.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: number of prefetch entries. Must be a power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: fetch request valid.
- `imem_addr`, output, 32: word address of the request. Bits [1:0] are always 0.
- `imem_gnt`, input, 1: memory accepts the request this cycle.
- `imem_rvalid`, input, 1: read data valid. Responses return in order.
- `imem_rdata`, input, 32: instruction word.
- `instr_valid`, output, 1: FIFO head valid toward decode.
- `instr_data`, output, 32: head instruction (feeds `idata`).
- `instr_pc`, output, 32: address of the head instruction (feeds `iaddr`).
- `instr_ready`, input, 1: decode consumes the head this cycle.
- `redirect`, input, 1: taken branch, jump or JALR resolved.
- `redirect_pc`, input, 32: new fetch target.
- `fetch_fault`, output, 1: misaligned redirect target. Present only under the macro; tied 0 otherwise.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `fetch_fault`=0. Internally, the PC is set to `RESET_PC`, the FIFO is emptied and both counters are 0.
- The state machine has three states.
  - BOOT: the state on reset. The block moves to RUN on the first clock after `reset` deasserts. No requests are issued in BOOT.
  - RUN: `imem_req`=1 whenever `fifo_count + outstanding < FIFO_DEPTH`. This guarantees that every response has a FIFO slot.
  - HALT: entered only under the macro. The block stops issuing requests until an aligned redirect arrives.
- Request acceptance (`imem_req && imem_gnt`):
  - `outstanding` increments.
  - The PC of the request is pushed onto an in-flight PC tag queue.
  - PC advances by 4 with 32-bit wrap-around; 32'hFFFF_FFFC is followed by 32'h0.
- Response (`imem_rvalid`):
  - `outstanding` decrements.
  - If `discard` > 0, the word is dropped and `discard` decrements.
  - Otherwise {tag PC, `imem_rdata`} is pushed to the FIFO.
- A grant and a response in the same cycle leave `outstanding` unchanged.
- Decode pop: `instr_valid && instr_ready` removes the head entry.
  - A push and a pop in the same cycle are legal at any occupancy, including full.
  - A pop when empty has no effect.
- Redirect (`redirect`=1 in RUN or HALT):
  - The FIFO is flushed; `instr_valid` is 0 on the next cycle.
  - PC loads `redirect_pc & 32'hFFFF_FFFC`.
  - `discard` loads the outstanding requests not answered this cycle, counting a request granted in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - A decode pop in the redirect cycle is ignored.
  - `imem_req` remains asserted on the redirect cycle with the old address. If that request is granted, it is discarded.
- New requests to the redirected PC may issue while `discard` > 0. Only the stale responses are dropped.
- A reset asserted mid-operation forces reset values immediately. In-flight memory responses after release are ignored, because `outstanding` is 0 and `imem_rvalid` is not counted in BOOT.

## Timing
- Grant in cycle N gives `imem_rvalid` in cycle N+1 at the earliest. The word appears on `instr_valid` in cycle N+2, because the FIFO output is registered and there is no bypass.
- With a zero-wait memory and `instr_ready` held at 1, the block sustains 1 instruction per cycle.
- From a redirect in cycle R, the earliest request for the target is in cycle R+1. The earliest `instr_valid` for the target is in cycle R+3.
- `imem_addr` is stable while `imem_req`=1 and `imem_gnt`=0, unless a redirect occurs.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` != 0 sets `fetch_fault`=1 and enters HALT.
  - In HALT, the FIFO is flushed and no requests are issued.
  - The next redirect with an aligned target clears `fetch_fault` and returns the block to RUN.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - The low bits of `redirect_pc` are silently masked.
  - HALT is unreachable and `fetch_fault` is constant 0.

## Structure
- `riscv_pkg` holds the shared definitions:
  - `fetch_entry_t` struct {`pc`[31:0], `data`[31:0]}
  - `fetch_state_e` enum {BOOT, RUN, HALT}
  - a default `RESET_PC` constant
- One sub-module, `fetch_fifo`, is parameterised by depth and entry type. It provides push, pop, flush, count, full and empty, and its output is registered.
- The in-flight PC tag queue is a second instance of `fetch_fifo` with depth `FIFO_DEPTH`.

## Test plan
- Reset sequence: hold `reset`=0, then release it with `RESET_PC`=0. The first `imem_addr` is 0x0 and is visible in the cycle after BOOT. Addresses then run 0x4, 0x8, … and `instr_pc` matches each address.
- Back-pressure: run with `instr_ready`=0 and a zero-wait memory. After 4 grants `imem_req` drops to 0 and `instr_valid`=1 with pc 0x0. Raising `instr_ready` drains the entries 0x0, 0x4, 0x8, 0xC in order.
- Redirect with in-flight fetches: hold 2 requests outstanding and assert `redirect` to 0x100. The next 2 responses are dropped. The first delivered `instr_pc` is 0x100, with no stale entries.
- Simultaneous events: a grant, a response and a pop in the same cycle at FIFO full leave occupancy unchanged with no loss. A redirect coinciding with a grant drops that response.
- Wrap-around: `redirect_pc`=0xFFFF_FFFC fetches 0xFFFF_FFFC and then 0x0000_0000.
- Misalignment, with `FETCH_MISALIGN_CHECK_EN` defined: `redirect_pc`=0x102 gives `fetch_fault`=1 and no further `imem_req`. A following redirect to 0x200 clears the fault and fetches 0x200.
